// File: rtl/serial_arith_pkg.sv
// ----------------------------------------------------------------------------
// serial_arith_pkg
// Shared definitions for the bit-serial arithmetic units (serial subtractor
// now, serial adder later). Holds the control state encoding so every serial
// unit decodes its handshake outputs from the same values.
// ----------------------------------------------------------------------------
package serial_arith_pkg;

  // Control states of a serial arithmetic unit.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage : serial_arith_pkg

// File: rtl/full_subtractor.sv
// ----------------------------------------------------------------------------
// full_subtractor
// One-bit full subtractor: computes x - y - bin.
// Ports:
//   x    in   minuend bit
//   y    in   subtrahend bit
//   bin  in   borrow in
//   diff out  difference bit
//   bout out  borrow out (1 when x < y + bin)
// Purely combinational.
// ----------------------------------------------------------------------------
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  // Borrow when y is set and x is clear, or when x == y and a borrow ripples in.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor: d = a - b - bi (mod 2^WIDTH), processed LSB first
// over WIDTH clock cycles through a single full-subtractor cell.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous, active-high reset
//   start  in   request, sampled only while ready = 1
//   a      in   minuend, captured on the accepted start edge
//   b      in   subtrahend, captured on the accepted start edge
//   bi     in   borrow in, captured on the accepted start edge
//   ready  out  high in IDLE
//   busy   out  high in SHIFT
//   done   out  one-cycle pulse; d/bo valid from this cycle
//   d      out  difference, held until the next completion or reset
//   bo     out  borrow out (1 when a < b + bi)
// All outputs come from registers or from the state register alone.
// ----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 4  // legal range 2..16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  import serial_arith_pkg::*;

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q,  sa_d;    // minuend shift register
  logic [WIDTH-1:0]   sb_q,  sb_d;    // subtrahend shift register
  logic               br_q,  br_d;    // running borrow
  logic [CNT_W-1:0]   cnt_q, cnt_d;   // bit index of the current step
  logic [WIDTH-1:0]   res_q, res_d;   // partial difference, filled from the MSB
  logic [WIDTH-1:0]   d_q,   d_d;
  logic               bo_q,  bo_d;

  logic               fs_diff;
  logic               fs_bout;

  full_subtractor u_fs (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (br_q),
    .diff (fs_diff),
    .bout (fs_bout)
  );

  always_comb begin
    // NOTE: every next-state signal gets a hold default before the case so
    // that no path leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    d_d     = d_q;
    bo_d    = bo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = bi;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // After WIDTH steps the first difference bit has reached bit 0.
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        br_d  = fs_bout;
        res_d = {fs_diff, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          d_d     = {fs_diff, res_q[WIDTH-1:1]};
          bo_d    = fs_bout;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      d_q     <= '0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_SHIFT);
  assign done  = (state_q == ST_DONE);
  assign d     = d_q;
  assign bo    = bo_q;

endmodule : serial_subtractor
